// File: rtl/vit_pkg.sv
// Shared parameters and FSM encoding for the Viterbi ACS step scheduler.
package vit_pkg;

  localparam int NUM_STATES_DEF = 64;
  localparam int PM_W_DEF       = 8;
  localparam int TB_LEN_DEF     = 32;
  localparam int NB_DEF         = NUM_STATES_DEF / 2;
  localparam int BF_IDX_W_DEF   = $clog2(NB_DEF);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/vit_pm_min.sv
// Running minimum of the ACS output metrics over one trellis step.
module vit_pm_min #(
  parameter int PM_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            update,
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  output logic [PM_W-1:0] cur_min
);

  logic [PM_W-1:0] acc_reg;
  logic [PM_W-1:0] pair_min;

  // cur_min already includes this cycle's pair, so the caller can latch the
  // full-step minimum on the last butterfly edge.
  always_comb begin
    pair_min = (pm0 < pm1) ? pm0 : pm1;
    cur_min  = load ? pair_min : ((acc_reg < pair_min) ? acc_reg : pair_min);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (load || update) begin
      acc_reg <= cur_min;
    end
  end

endmodule

// File: rtl/vit_acs_sched.sv
// Butterfly scheduler for the shared ACS: symbol capture, bank ping-pong,
// per-step normalization minimum and traceback trigger.
module vit_acs_sched
  import vit_pkg::*;
#(
  parameter int NUM_STATES = NUM_STATES_DEF,
  parameter int PM_W       = PM_W_DEF,
  parameter int TB_LEN     = TB_LEN_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rx_valid,
  input  logic [1:0]                        rx_pair,
  output logic                              rx_ready,
  output logic [1:0]                        bf_rx_pair,
  output logic                              bf_en,
  output logic [$clog2(NUM_STATES/2)-1:0]   bf_idx,
  output logic                              pm_rd_bank,
  output logic                              init_en,
  input  logic [PM_W-1:0]                   acs_pm0,
  input  logic [PM_W-1:0]                   acs_pm1,
  output logic [PM_W-1:0]                   pm_sub,
  output logic                              step_done,
  output logic                              tb_trigger
);

  localparam int NB       = NUM_STATES / 2;
  localparam int BF_IDX_W = $clog2(NB);
  localparam int CNT_W    = $clog2(TB_LEN);
  localparam logic [BF_IDX_W-1:0] LAST_BF   = BF_IDX_W'(NB - 1);
  localparam logic [CNT_W-1:0]    LAST_STEP = CNT_W'(TB_LEN - 1);

  state_t              state_reg, state_next;
  logic [BF_IDX_W-1:0] idx_reg, idx_next;
  logic [1:0]          pair_reg, pair_next;
  logic                bank_reg;
  logic [PM_W-1:0]     sub_reg;
  logic                done_reg;
  logic                trig_reg;
  logic [CNT_W-1:0]    step_cnt_reg;
  logic                last_bf;
  logic                step_end;
  logic                in_init;
  logic [PM_W-1:0]     step_min;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    pair_next  = pair_reg;
    rx_ready   = 1'b0;
    bf_en      = 1'b0;
    in_init    = 1'b0;
    step_end   = 1'b0;
    last_bf    = (idx_reg == LAST_BF);
    case (state_reg)
      INIT: begin
        in_init  = 1'b1;
        idx_next = idx_reg + 1'b1;
        if (last_bf) begin
          idx_next   = '0;
          state_next = IDLE;
        end
      end
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          pair_next  = rx_pair;
          idx_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        bf_en    = 1'b1;
        idx_next = idx_reg + 1'b1;
        if (last_bf) begin
          // Accepting here lets consecutive symbols run with no bubble.
          step_end = 1'b1;
          rx_ready = 1'b1;
          idx_next = '0;
          if (rx_valid) pair_next = rx_pair;
          else          state_next = IDLE;
        end
      end
      default: state_next = INIT;
    endcase
  end

  // INIT is also the reset state, so the strobe is held off while rst_n is low.
  assign init_en = in_init && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= INIT;
      idx_reg      <= '0;
      pair_reg     <= 2'b00;
      bank_reg     <= 1'b0;
      sub_reg      <= '0;
      done_reg     <= 1'b0;
      trig_reg     <= 1'b0;
      step_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      pair_reg  <= pair_next;
      done_reg  <= step_end;
      trig_reg  <= step_end && (step_cnt_reg == LAST_STEP);
      if (step_end) begin
        bank_reg     <= ~bank_reg;
        sub_reg      <= step_min;
        step_cnt_reg <= (step_cnt_reg == LAST_STEP) ? '0 : step_cnt_reg + 1'b1;
      end
    end
  end

  vit_pm_min #(
    .PM_W(PM_W)
  ) u_pm_min (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (bf_en && (idx_reg == '0)),
    .update (bf_en),
    .pm0    (acs_pm0),
    .pm1    (acs_pm1),
    .cur_min(step_min)
  );

  assign bf_idx     = idx_reg;
  assign bf_rx_pair = pair_reg;
  assign pm_rd_bank = bank_reg;
  assign pm_sub     = sub_reg;
  assign step_done  = done_reg;
  assign tb_trigger = trig_reg;

endmodule
